// File: rtl/folded_conv_engine.sv
// Folded single-MAC convolution engine: sequences fmap/weight SRAM reads
// and accumulates TAPS signed products per strided output window.
module folded_conv_engine #(
  parameter int DW      = 8,
  parameter int WW      = 8,
  parameter int ACC_W   = 21,
  parameter int TAPS    = 64,
  parameter int NUM_OUT = 1,
  parameter int STRIDE  = 1,
  parameter int NSETS   = 2,
  parameter int FA_W    = 6,
  parameter int WA_W    = 7,
  localparam int SW     = (NSETS > 1) ? $clog2(NSETS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SW-1:0]           weight_select,
  output logic                    mem_ce,
  output logic [FA_W-1:0]         addr_fmaps,
  output logic [WA_W-1:0]         addr_weight,
  input  logic [DW-1:0]           data_fmaps,
  input  logic [WW-1:0]           data_weight,
  output logic signed [ACC_W-1:0] acc,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf
);

  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int NW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int PW = DW + WW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_EMIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [KW-1:0]           r_k;
  logic [NW-1:0]           r_win;
  logic [SW-1:0]           r_wsel;
  logic                    r_dv;
  logic                    r_first;
  logic signed [ACC_W-1:0] r_sum;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_ovf;

  logic                    w_accept;
  logic                    w_k_last;
  logic                    w_win_last;
  logic signed [PW-1:0]    w_fx;
  logic signed [PW-1:0]    w_wx;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W:0]   w_prod_x;
  logic signed [ACC_W:0]   w_base;
  logic signed [ACC_W:0]   w_raw;
  logic                    w_clamp;
  logic signed [ACC_W-1:0] w_sat;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_k_last   = (r_k == KW'(TAPS - 1));
  assign w_win_last = (r_win == NW'(NUM_OUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: if (w_k_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_EMIT;
      S_EMIT:  w_next = w_win_last ? S_IDLE : S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= '0;
      r_win   <= '0;
      r_wsel  <= '0;
      r_dv    <= 1'b0;
      r_first <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wsel <= weight_select;
        r_win  <= '0;
        r_k    <= '0;
      end
      if (r_state == S_FETCH) begin
        r_k <= w_k_last ? '0 : r_k + KW'(1);
      end
      if ((r_state == S_EMIT) && !w_win_last) begin
        r_win <= r_win + NW'(1);
      end
      // SRAM data lags the address by one cycle
      r_dv    <= (r_state == S_FETCH);
      r_first <= (r_state == S_FETCH) && (r_k == '0);
    end
  end

  assign w_fx     = $signed({{WW{data_fmaps[DW-1]}}, data_fmaps});
  assign w_wx     = $signed({{DW{data_weight[WW-1]}}, data_weight});
  assign w_prod   = w_fx * w_wx;
  assign w_prod_x = (ACC_W + 1)'(w_prod);
  assign w_base   = r_first ? '0 : {r_sum[ACC_W-1], r_sum};
  assign w_raw    = w_base + w_prod_x;
  assign w_clamp  = w_raw[ACC_W] ^ w_raw[ACC_W-1];

  always_comb begin
    w_sat = w_raw[ACC_W-1:0];
    if (w_clamp) begin
      w_sat = w_raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (r_dv) begin
        r_sum <= w_sat;
      end
      if (r_state == S_DRAIN) begin
        r_acc <= w_sat;
      end
      if (w_accept) begin
        r_ovf <= 1'b0;
      end else if (r_dv && w_clamp) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign mem_ce      = (r_state == S_FETCH);
  assign addr_fmaps  = mem_ce ? FA_W'(r_win) * FA_W'(STRIDE) + FA_W'(r_k)
                              : '0;
  assign addr_weight = mem_ce ? WA_W'(r_wsel) * WA_W'(TAPS) + WA_W'(r_k)
                              : '0;
  assign acc         = r_acc;
  assign out_valid   = (r_state == S_EMIT);
  assign done        = out_valid && w_win_last;
  assign busy        = (r_state != S_IDLE);
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_folded_conv_engine.sv
// Randomised scoreboard bench for folded_conv_engine with three
// stride-2 windows per frame and SRAM models with 1-cycle read latency.
module tb_folded_conv_engine;

  localparam int  TAPS  = 64;
  localparam int  NOUT  = 3;
  localparam int  STR   = 2;
  localparam int  WPER  = TAPS + 2;
  localparam longint AMAX = 1048575;
  localparam longint AMIN = -1048576;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               weight_select = 1'b0;
  logic               mem_ce;
  logic [5:0]         addr_fmaps;
  logic [6:0]         addr_weight;
  logic signed [7:0]  data_fmaps = '0;
  logic signed [7:0]  data_weight = '0;
  logic signed [20:0] acc;
  logic               out_valid;
  logic               busy;
  logic               done;
  logic               ovf;

  folded_conv_engine #(
    .NUM_OUT(NOUT),
    .STRIDE (STR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .weight_select(weight_select),
    .mem_ce       (mem_ce),
    .addr_fmaps   (addr_fmaps),
    .addr_weight  (addr_weight),
    .data_fmaps   (data_fmaps),
    .data_weight  (data_weight),
    .acc          (acc),
    .out_valid    (out_valid),
    .busy         (busy),
    .done         (done),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [7:0] fmem [64];
  logic signed [7:0] wmem [128];

  always @(posedge clk) begin
    if (mem_ce) begin
      data_fmaps  <= fmem[addr_fmaps];
      data_weight <= wmem[addr_weight];
    end
  end

  typedef struct {
    longint acc;
    bit     done;
    bit     ovf;
    longint cyc;
  } exp_t;

  exp_t   exp_q [$];
  int     checks = 0;
  int     failures = 0;
  bit     frame_on = 1'b0;
  longint exp_c0 = 0;
  int     exp_ws = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_ce"}, mem_ce, 0);
    chk({tag, "_addr_fmaps"}, addr_fmaps, 0);
    chk({tag, "_addr_weight"}, addr_weight, 0);
    chk({tag, "_acc"}, acc, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  // Called at a negedge with the engine idle; returns at a negedge.
  task automatic start_frame(input int ws);
    longint s;
    bit     ov;
    exp_t   e;
    start = 1'b1;
    weight_select = ws[0];
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_c0 = cyc;
    exp_ws = ws;
    frame_on = 1'b1;
    chk("busy_on_start", busy, 1);
    chk("ovf_cleared", ovf, 0);
    ov = 1'b0;
    for (int w = 0; w < NOUT; w++) begin
      s = 0;
      for (int k = 0; k < TAPS; k++) begin
        s += longint'(fmem[(w * STR + k) % 64]) *
             longint'(wmem[(ws * TAPS + k) % 128]);
        if (s > AMAX) begin
          s = AMAX;
          ov = 1'b1;
        end else if (s < AMIN) begin
          s = AMIN;
          ov = 1'b1;
        end
      end
      e.acc  = s;
      e.done = (w == NOUT - 1);
      e.ovf  = ov;
      e.cyc  = exp_c0 + WPER - 1 + longint'(WPER * w);
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("idle_timeout", busy, 0);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) fmem[i] = 8'($urandom);
    for (int i = 0; i < 128; i++) wmem[i] = 8'($urandom);
  endtask

  longint d;
  longint ph;
  exp_t   got_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_on) begin
        d = cyc - exp_c0;
        if (d < longint'(WPER * NOUT)) begin
          ph = d % WPER;
          chk("mem_ce", mem_ce, longint'(ph < TAPS));
          if (ph < TAPS) begin
            chk("addr_fmaps", addr_fmaps, ((d / WPER) * STR + ph) % 64);
            chk("addr_weight", addr_weight, exp_ws * TAPS + ph);
          end
          chk("busy", busy, 1);
        end else if (d == longint'(WPER * NOUT)) begin
          chk("busy_fall", busy, 0);
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid: acc=%0d at cycle %0d, none required",
                   acc, cyc);
        end else begin
          got_e = exp_q.pop_front();
          chk("acc", acc, got_e.acc);
          chk("done", done, longint'(got_e.done));
          chk("ovf", ovf, longint'(got_e.ovf));
          chk("out_valid_cycle", cyc, got_e.cyc);
        end
      end else if (done) begin
        chk("done_without_valid", done, 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) fmem[i] = '0;
    for (int i = 0; i < 128; i++) wmem[i] = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 64; i++) fmem[i] = 8'sd1;
    for (int i = 0; i < 128; i++) wmem[i] = 8'sd1;
    start_frame(0);
    wait_idle();

    for (int i = 0; i < 64; i++) fmem[i] = 8'(i);
    for (int i = 0; i < 128; i++) wmem[i] = -8'sd1;
    start_frame(1);
    wait_idle();

    for (int i = 0; i < 64; i++) fmem[i] = -8'sd128;
    for (int i = 0; i < 128; i++) wmem[i] = -8'sd128;
    start_frame(0);
    wait_idle();

    for (int i = 0; i < 64; i++) fmem[i] = 8'(i);
    for (int i = 0; i < 128; i++) wmem[i] = 8'sd1;
    start_frame(0);
    wait_idle();

    fill_rand();
    start_frame(1);
    repeat (10) @(negedge clk);
    start = 1'b1;
    weight_select = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    fill_rand();
    start_frame(0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    frame_on = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    start_frame(1);
    wait_idle();

    repeat (8) begin
      fill_rand();
      start_frame(int'($urandom_range(0, 1)));
      wait_idle();
    end

    repeat (150) @(negedge clk);
    chk("leftover_expected", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
